// File: rtl/noc_node_ni.sv
// rtl/noc_node_ni.sv - credit-gated injection FIFO and credit-returning ejection FIFO between router port 5 and a PE.
// Define NODE_NI_STATS_EN to add the inj_count/ej_count statistics ports.
module noc_node_ni #(
    parameter int FLIT_W    = 20,
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4,
    parameter int CREDITS   = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [FLIT_W-1:0] pe_flit_in,
    input  logic              pe_valid_in,
    output logic              pe_ready_out,
    output logic [FLIT_W-1:0] net_flit_out,
    output logic              net_valid_out,
    input  logic              net_credit_in,
    input  logic [FLIT_W-1:0] net_flit_in,
    input  logic              net_valid_in,
    output logic              net_credit_out,
    output logic [FLIT_W-1:0] pe_flit_out,
    output logic              pe_valid_out,
    input  logic              pe_ready_in,
    output logic [1:0]        err
`ifdef NODE_NI_STATS_EN
    ,
    output logic [CNT_W-1:0]  inj_count,
    output logic [CNT_W-1:0]  ej_count
`endif
);
    localparam int IPW = $clog2(INJ_DEPTH);
    localparam int IOW = $clog2(INJ_DEPTH + 1);
    localparam int EPW = $clog2(EJ_DEPTH);
    localparam int EOW = $clog2(EJ_DEPTH + 1);
    localparam int CW  = $clog2(CREDITS + 1);

    localparam logic [IPW-1:0] INJ_PTR_ONE = IPW'(1);
    localparam logic [IOW-1:0] INJ_OCC_ONE = IOW'(1);
    localparam logic [IOW-1:0] INJ_FULL    = IOW'(INJ_DEPTH);
    localparam logic [EPW-1:0] EJ_PTR_ONE  = EPW'(1);
    localparam logic [EOW-1:0] EJ_OCC_ONE  = EOW'(1);
    localparam logic [EOW-1:0] EJ_FULL     = EOW'(EJ_DEPTH);
    localparam logic [CW-1:0]  CRED_ONE    = CW'(1);
    localparam logic [CW-1:0]  CRED_MAX    = CW'(CREDITS);

    logic [FLIT_W-1:0] r_inj_mem [INJ_DEPTH];
    logic [IPW-1:0]    r_inj_wr;
    logic [IPW-1:0]    r_inj_rd;
    logic [IOW-1:0]    r_inj_occ;
    logic [FLIT_W-1:0] r_ej_mem [EJ_DEPTH];
    logic [EPW-1:0]    r_ej_wr;
    logic [EPW-1:0]    r_ej_rd;
    logic [EOW-1:0]    r_ej_occ;
    logic [CW-1:0]     r_credit_cnt;
    logic [FLIT_W-1:0] r_net_flit;
    logic              r_net_valid;
    logic              r_net_credit;
    logic [1:0]        r_err;

    logic w_inj_full;
    logic w_inj_wr;
    logic w_send;
    logic w_ej_full;
    logic w_ej_pop;
    logic w_ej_wr;

    // Ready comes from registered occupancy only, so a full FIFO stays closed even on a pop cycle.
    assign w_inj_full   = (r_inj_occ == INJ_FULL);
    assign pe_ready_out = !RST && !w_inj_full;
    assign w_inj_wr     = pe_valid_in && pe_ready_out;
    assign w_send       = (r_inj_occ != '0) && (r_credit_cnt != '0);

    assign w_ej_full    = (r_ej_occ == EJ_FULL);
    assign pe_valid_out = (r_ej_occ != '0);
    assign pe_flit_out  = pe_valid_out ? r_ej_mem[r_ej_rd] : '0;
    assign w_ej_pop     = pe_valid_out && pe_ready_in;
    assign w_ej_wr      = net_valid_in && (!w_ej_full || w_ej_pop);

    assign net_flit_out   = r_net_flit;
    assign net_valid_out  = r_net_valid;
    assign net_credit_out = r_net_credit;
    assign err            = r_err;

    always_ff @(posedge clk) begin
        if (w_inj_wr) r_inj_mem[r_inj_wr] <= pe_flit_in;
        if (w_ej_wr)  r_ej_mem[r_ej_wr]   <= net_flit_in;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_inj_wr     <= '0;
            r_inj_rd     <= '0;
            r_inj_occ    <= '0;
            r_ej_wr      <= '0;
            r_ej_rd      <= '0;
            r_ej_occ     <= '0;
            r_credit_cnt <= CRED_MAX;
            r_net_flit   <= '0;
            r_net_valid  <= 1'b0;
            r_net_credit <= 1'b0;
            r_err        <= 2'b00;
        end else begin
            r_net_valid  <= w_send;
            r_net_credit <= w_ej_pop;
            if (w_send) begin
                r_net_flit <= r_inj_mem[r_inj_rd];
                r_inj_rd   <= r_inj_rd + INJ_PTR_ONE;
            end
            if (w_inj_wr) r_inj_wr <= r_inj_wr + INJ_PTR_ONE;
            case ({w_inj_wr, w_send})
                2'b10:   r_inj_occ <= r_inj_occ + INJ_OCC_ONE;
                2'b01:   r_inj_occ <= r_inj_occ - INJ_OCC_ONE;
                default: r_inj_occ <= r_inj_occ;
            endcase

            // A credit arriving on a send cycle cancels the decrement.
            if (net_credit_in && !w_send) begin
                if (r_credit_cnt == CRED_MAX) r_err[0] <= 1'b1;
                else                          r_credit_cnt <= r_credit_cnt + CRED_ONE;
            end else if (w_send && !net_credit_in) begin
                r_credit_cnt <= r_credit_cnt - CRED_ONE;
            end

            if (w_ej_pop) r_ej_rd <= r_ej_rd + EJ_PTR_ONE;
            if (w_ej_wr)  r_ej_wr <= r_ej_wr + EJ_PTR_ONE;
            if (net_valid_in && !w_ej_wr) r_err[1] <= 1'b1;
            case ({w_ej_wr, w_ej_pop})
                2'b10:   r_ej_occ <= r_ej_occ + EJ_OCC_ONE;
                2'b01:   r_ej_occ <= r_ej_occ - EJ_OCC_ONE;
                default: r_ej_occ <= r_ej_occ;
            endcase
        end
    end

`ifdef NODE_NI_STATS_EN
    always_ff @(posedge clk) begin
        if (RST) begin
            inj_count <= '0;
            ej_count  <= '0;
        end else begin
            if (w_send)  inj_count <= inj_count + CNT_W'(1);
            if (w_ej_wr) ej_count  <= ej_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_noc_node_ni.sv
// tb/tb_noc_node_ni.sv - queue-model scoreboard with directed scenarios and random traffic for noc_node_ni.
module tb_noc_node_ni;
    localparam int DEP = 4;
    localparam int CRD = 4;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [19:0] pe_flit_in = '0;
    logic        pe_valid_in = 1'b0;
    logic        pe_ready_out;
    logic [19:0] net_flit_out;
    logic        net_valid_out;
    logic        net_credit_in = 1'b0;
    logic [19:0] net_flit_in = '0;
    logic        net_valid_in = 1'b0;
    logic        net_credit_out;
    logic [19:0] pe_flit_out;
    logic        pe_valid_out;
    logic        pe_ready_in = 1'b0;
    logic [1:0]  err;
`ifdef NODE_NI_STATS_EN
    logic [15:0] inj_count;
    logic [15:0] ej_count;
`endif

    noc_node_ni dut (
        .clk(clk), .RST(RST),
        .pe_flit_in(pe_flit_in), .pe_valid_in(pe_valid_in), .pe_ready_out(pe_ready_out),
        .net_flit_out(net_flit_out), .net_valid_out(net_valid_out), .net_credit_in(net_credit_in),
        .net_flit_in(net_flit_in), .net_valid_in(net_valid_in), .net_credit_out(net_credit_out),
        .pe_flit_out(pe_flit_out), .pe_valid_out(pe_valid_out), .pe_ready_in(pe_ready_in),
        .err(err)
`ifdef NODE_NI_STATS_EN
        , .inj_count(inj_count), .ej_count(ej_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [19:0] inj_q[$];
    logic [19:0] ej_q[$];
    int          m_cr = CRD;
    logic [1:0]  m_err = 2'b00;
    logic        m_nv = 1'b0;
    logic [19:0] m_nf = '0;
    logic        m_co = 1'b0;
    int          m_ic = 0;
    int          m_ec = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, applied to the inputs held across that edge.
    task automatic step();
        bit snd, pop;
        if (RST) begin
            inj_q.delete();
            ej_q.delete();
            m_cr = CRD; m_err = 2'b00; m_nv = 1'b0; m_nf = '0; m_co = 1'b0;
            m_ic = 0; m_ec = 0;
        end else begin
            bit rdy;
            rdy = inj_q.size() < DEP;
            snd = (inj_q.size() > 0) && (m_cr > 0);
            m_nv = snd;
            if (snd) begin
                m_nf = inj_q.pop_front();
                m_ic++;
            end
            if (pe_valid_in && rdy) inj_q.push_back(pe_flit_in);
            if (net_credit_in && !snd) begin
                if (m_cr == CRD) m_err[0] = 1'b1;
                else m_cr++;
            end else if (snd && !net_credit_in) begin
                m_cr--;
            end
            pop = (ej_q.size() > 0) && pe_ready_in;
            if (net_valid_in) begin
                if (ej_q.size() < DEP || pop) m_ec++;
                else m_err[1] = 1'b1;
            end
            if (pop) void'(ej_q.pop_front());
            if (net_valid_in && (ej_q.size() < DEP)) ej_q.push_back(net_flit_in);
            m_co = pop;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pe_ready_out", 32'(pe_ready_out), 32'(!RST && (inj_q.size() < DEP)));
            chk("net_valid_out", 32'(net_valid_out), 32'(m_nv));
            chk("net_flit_out", 32'(net_flit_out), 32'(m_nf));
            chk("pe_valid_out", 32'(pe_valid_out), 32'(ej_q.size() != 0));
            if (ej_q.size() != 0) chk("pe_flit_out", 32'(pe_flit_out), 32'(ej_q[0]));
            chk("net_credit_out", 32'(net_credit_out), 32'(m_co));
            chk("err", 32'(err), 32'(m_err));
            chk("credit_cnt", 32'(dut.r_credit_cnt), 32'(m_cr));
`ifdef NODE_NI_STATS_EN
            chk("inj_count", 32'(inj_count), 32'(m_ic & 16'hFFFF));
            chk("ej_count", 32'(ej_count), 32'(m_ec & 16'hFFFF));
`endif
        end
    end

    initial begin
        int cnt;
        cyc(); cyc();
        chk_en = 1'b1;
        chk("rst_net_valid", 32'(net_valid_out), 32'd0);
        chk("rst_pe_valid", 32'(pe_valid_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_credit", 32'(dut.r_credit_cnt), 32'd4);
        chk("rst_ready_low", 32'(pe_ready_out), 32'd0);
        RST = 1'b0;
        #1;
        chk("rst_ready_high", 32'(pe_ready_out), 32'd1);

        // Credit exhaustion: six flits offered, only four leave without credit returns.
        cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            pe_valid_in = 1'b1; pe_flit_in = 20'(i);
            cyc();
            if (net_valid_out) cnt++;
        end
        pe_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (net_valid_out) cnt++;
        end
        chk("s1_sent", 32'(cnt), 32'd4);
        chk("s1_last_flit", 32'(net_flit_out), 32'h00004);
        chk("s1_credit0", 32'(dut.r_credit_cnt), 32'd0);
        net_credit_in = 1'b1; cyc(); net_credit_in = 1'b0;
        chk("s1_no_send_yet", 32'(net_valid_out), 32'd0);
        cyc();
        chk("s1_send5_valid", 32'(net_valid_out), 32'd1);
        chk("s1_send5_flit", 32'(net_flit_out), 32'h00005);
        chk("s1_credit_after", 32'(dut.r_credit_cnt), 32'd0);

        // Send and credit on the same edge leave the counter unchanged.
        net_credit_in = 1'b1; pe_valid_in = 1'b1; pe_flit_in = 20'h00007; cyc();
        pe_valid_in = 1'b0; cyc();
        net_credit_in = 1'b0;
        chk("s2_flit6", 32'(net_flit_out), 32'h00006);
        chk("s2_credit_hold", 32'(dut.r_credit_cnt), 32'd1);
        cyc();
        chk("s2_flit7_valid", 32'(net_valid_out), 32'd1);
        chk("s2_flit7", 32'(net_flit_out), 32'h00007);

        // Full injection FIFO refuses a write.
        for (int i = 0; i < 4; i++) begin
            pe_valid_in = 1'b1; pe_flit_in = 20'(16 + i); cyc();
        end
        chk("s4_ready_full", 32'(pe_ready_out), 32'd0);
        pe_flit_in = 20'h0FFFF; cyc(); pe_valid_in = 1'b0;
        chk("s4_ready_still", 32'(pe_ready_out), 32'd0);
        net_credit_in = 1'b1; cyc(); net_credit_in = 1'b0; cyc();
        chk("s4_sent_head", 32'(net_flit_out), 32'h00010);
        chk("s4_ready_back", 32'(pe_ready_out), 32'd1);
        net_credit_in = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        net_credit_in = 1'b0; cyc();
        chk("s4_last_flit", 32'(net_flit_out), 32'h00013);
        chk("s4_credit_full", 32'(dut.r_credit_cnt), 32'd4);

        // Excess credit.
        net_credit_in = 1'b1; cyc(); net_credit_in = 1'b0;
        chk("s5_err0", 32'(err[0]), 32'd1);
        chk("s5_credit4", 32'(dut.r_credit_cnt), 32'd4);

        // Ejection under backpressure, overflow, then drain with credit pulses.
        for (int i = 0; i < 4; i++) begin
            net_valid_in = 1'b1; net_flit_in = 20'hA0000 + 20'(i); cyc();
        end
        net_valid_in = 1'b0;
        chk("s3_valid", 32'(pe_valid_out), 32'd1);
        chk("s3_head", 32'(pe_flit_out), 32'hA0000);
        net_valid_in = 1'b1; net_flit_in = 20'hA0004; cyc(); net_valid_in = 1'b0;
        chk("s3_err", 32'(err), 32'd3);
        pe_ready_in = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (net_credit_out) cnt++;
        end
        pe_ready_in = 1'b0;
        chk("s3_pulses", 32'(cnt), 32'd4);
        chk("s3_empty", 32'(pe_valid_out), 32'd0);
        cyc();
        chk("s3_pulse_end", 32'(net_credit_out), 32'd0);

        // Reset with both FIFOs partly filled.
        for (int i = 0; i < 6; i++) begin
            pe_valid_in = 1'b1; pe_flit_in = 20'h30 + 20'(i); cyc();
        end
        pe_valid_in = 1'b0; cyc();
        for (int i = 0; i < 2; i++) begin
            net_valid_in = 1'b1; net_flit_in = 20'hB0000 + 20'(i); cyc();
        end
        net_valid_in = 1'b0;
        RST = 1'b1; pe_ready_in = 1'b1; cyc();
        chk("s6_net_valid", 32'(net_valid_out), 32'd0);
        chk("s6_net_flit", 32'(net_flit_out), 32'd0);
        chk("s6_pe_valid", 32'(pe_valid_out), 32'd0);
        chk("s6_credit", 32'(dut.r_credit_cnt), 32'd4);
        chk("s6_err", 32'(err), 32'd0);
        chk("s6_no_pulse", 32'(net_credit_out), 32'd0);
`ifdef NODE_NI_STATS_EN
        chk("s6_inj_count", 32'(inj_count), 32'd0);
        chk("s6_ej_count", 32'(ej_count), 32'd0);
`endif
        RST = 1'b0; pe_ready_in = 1'b0; cyc();
        chk("s6_no_pulse_after", 32'(net_credit_out), 32'd0);
        chk("s6_no_send_after", 32'(net_valid_out), 32'd0);

        // Random traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            RST           = ($urandom_range(0, 199) == 0);
            pe_valid_in   = ($urandom_range(0, 9) < 6);
            pe_flit_in    = 20'($urandom);
            net_credit_in = ($urandom_range(0, 9) < 3);
            net_valid_in  = ($urandom_range(0, 9) < 4);
            net_flit_in   = 20'($urandom);
            pe_ready_in   = ($urandom_range(0, 1) == 1);
            cyc();
        end
        RST = 1'b0; pe_valid_in = 1'b0; net_credit_in = 1'b0; net_valid_in = 1'b0; pe_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
